// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbiter issuing CLR/SET/TOGGLE/LOAD commands to a shared JK bank
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      cmd,
    input  logic [WIDTH*NREQ-1:0]  arg,
    input  logic [WIDTH-1:0]       q_in,
    output logic [WIDTH-1:0]       j_out,
    output logic [WIDTH-1:0]       k_out,
    output logic [NREQ-1:0]        gnt,
    output logic                   err,
    output logic                   busy
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, DRIVE, VERIFY} state_t;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_TOG = 2'b10;

    state_t            state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  arg_q, arg_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [IW-1:0]     win_idx;
    logic              win_found;

    // Rotating priority scan starting at rr_q
    always_comb begin
        win_idx   = rr_q;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int t;
            t = int'(rr_q) + k;
            if (t >= NREQ) t = t - NREQ;
            if (!win_found && req[t]) begin
                win_found = 1'b1;
                win_idx   = IW'(t);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            op_q    <= '0;
            arg_q   <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        op_d    = op_q;
        arg_d   = arg_q;
        exp_d   = exp_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = DRIVE;
                    win_d   = win_idx;
                    op_d    = cmd[2*win_idx +: 2];
                    arg_d   = arg[WIDTH*win_idx +: WIDTH];
                end
            end
            DRIVE: begin
                // q_in still holds the pre-update bank value here
                state_d = VERIFY;
                case (op_q)
                    OP_CLR:  exp_d = q_in & ~arg_q;
                    OP_SET:  exp_d = q_in | arg_q;
                    OP_TOG:  exp_d = q_in ^ arg_q;
                    default: exp_d = arg_q;
                endcase
            end
            VERIFY: begin
                state_d = IDLE;
                rr_d    = (win_q == IW'(NREQ-1)) ? '0 : win_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        j_out = '0;
        k_out = '0;
        gnt   = '0;
        err   = 1'b0;
        busy  = (state_q != IDLE);
        case (state_q)
            DRIVE: begin
                case (op_q)
                    OP_CLR:  begin j_out = '0;    k_out = arg_q;  end
                    OP_SET:  begin j_out = arg_q; k_out = '0;     end
                    OP_TOG:  begin j_out = arg_q; k_out = arg_q;  end
                    default: begin j_out = arg_q; k_out = ~arg_q; end
                endcase
            end
            VERIFY: begin
                gnt[win_q] = 1'b1;
                err        = (q_in != exp_q);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - directed self-checking bench for jk_bank_arbiter with a JK bank model
module tb_jk_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     cmd;
    logic [WIDTH*NREQ-1:0] arg;
    logic [WIDTH-1:0]      q_in, j_out, k_out, bank_q, preload_val;
    logic [NREQ-1:0]       gnt;
    logic                  err, busy, preload, stuck;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .arg(arg), .q_in(q_in),
        .j_out(j_out), .k_out(k_out), .gnt(gnt), .err(err), .busy(busy)
    );

    always_ff @(posedge clk) begin
        if (rst)          bank_q <= '0;
        else if (preload) bank_q <= preload_val;
        else              bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
    end
    assign q_in = stuck ? '0 : bank_q;

    task automatic set_req(input int i, input logic [1:0] c, input logic [WIDTH-1:0] a);
        req[i]             = 1'b1;
        cmd[2*i +: 2]      = c;
        arg[WIDTH*i +: WIDTH] = a;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_gnt(output logic found);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            if (gnt != 0) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; cmd = '0; arg = '0; preload = 1'b0; preload_val = '0; stuck = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== '0 || err !== 1'b0 || busy !== 1'b0 || j_out !== '0 || k_out !== '0) begin
            errors++;
            $display("FAIL reset: gnt=%b err=%b busy=%b j=%h k=%h, required all zero", gnt, err, busy, j_out, k_out);
        end
    endtask

    task automatic test_set();
        set_req(0, 2'b01, 8'h0F);
        step();
        checks++;
        if (j_out !== 8'h0F || k_out !== 8'h00 || busy !== 1'b1 || gnt !== '0) begin
            errors++;
            $display("FAIL set_drive: j=%h k=%h busy=%b gnt=%b, required j=0f k=00 busy=1 gnt=0", j_out, k_out, busy, gnt);
        end
        step();
        checks++;
        if (gnt !== 4'b0001 || err !== 1'b0 || bank_q !== 8'h0F || j_out !== '0 || k_out !== '0) begin
            errors++;
            $display("FAIL set_verify: gnt=%b err=%b q=%h j=%h k=%h, required gnt=0001 err=0 q=0f j=k=0", gnt, err, bank_q, j_out, k_out);
        end
        req = '0;
        step();
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL set_idle: gnt=%b busy=%b, required 0 0", gnt, busy);
        end
    endtask

    task automatic test_toggle_load();
        preload = 1'b1; preload_val = 8'hF0;
        step();
        preload = 1'b0;
        set_req(1, 2'b10, 8'hFF);
        step();
        checks++;
        if (j_out !== 8'hFF || k_out !== 8'hFF) begin
            errors++;
            $display("FAIL tog_drive: j=%h k=%h, required ff ff", j_out, k_out);
        end
        step();
        checks++;
        if (gnt !== 4'b0010 || err !== 1'b0 || bank_q !== 8'h0F) begin
            errors++;
            $display("FAIL tog_verify: gnt=%b err=%b q=%h, required 0010 0 0f", gnt, err, bank_q);
        end
        req = '0;
        step();
        set_req(3, 2'b11, 8'hA5);
        step();
        checks++;
        if (j_out !== 8'hA5 || k_out !== 8'h5A) begin
            errors++;
            $display("FAIL load_drive: j=%h k=%h, required a5 5a", j_out, k_out);
        end
        step();
        checks++;
        if (gnt !== 4'b1000 || err !== 1'b0 || bank_q !== 8'hA5) begin
            errors++;
            $display("FAIL load_verify: gnt=%b err=%b q=%h, required 1000 0 a5", gnt, err, bank_q);
        end
        req = '0;
        step();
    endtask

    task automatic test_zero_mask();
        set_req(3, 2'b10, 8'h00);
        step();
        checks++;
        if (j_out !== 8'h00 || k_out !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_drive: j=%h k=%h busy=%b, required 00 00 1", j_out, k_out, busy);
        end
        step();
        checks++;
        if (gnt !== 4'b1000 || err !== 1'b0 || bank_q !== 8'hA5) begin
            errors++;
            $display("FAIL zero_verify: gnt=%b err=%b q=%h, required 1000 0 a5", gnt, err, bank_q);
        end
        req = '0;
        step();
    endtask

    task automatic test_back_to_back();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int ng = 0;
        int last = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 8'h00);
        for (int c = 0; c < 20 && ng < 5; c++) begin
            step();
            if ($countones(gnt) > 1) begin
                checks++; errors++;
                $display("FAIL rr_onehot: gnt=%b, required at most one bit", gnt);
            end
            if (gnt != 0) begin
                checks++;
                if (gnt !== NREQ'(1 << exp_order[ng]) || (ng > 0 && c - last != 3)) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d gnt=%b spacing=%0d, required requester %0d spacing 3", ng, gnt, c - last, exp_order[ng]);
                end
                last = c;
                ng++;
                if (ng == 5) req = '0;
            end
        end
        checks++;
        if (ng != 5) begin
            errors++;
            $display("FAIL rr_count: %0d grants, required 5", ng);
        end
        step();
    endtask

    task automatic test_priority();
        logic found;
        set_req(1, 2'b01, 8'h00);
        wait_gnt(found);
        checks++;
        if (!found || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL prio_setup: found=%b gnt=%b, required 0010", found, gnt);
        end
        req = '0;
        step();
        set_req(0, 2'b01, 8'h00);
        set_req(1, 2'b01, 8'h00);
        wait_gnt(found);
        checks++;
        if (!found || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL prio_first: found=%b gnt=%b, required 0001", found, gnt);
        end
        req[0] = 1'b0;
        wait_gnt(found);
        checks++;
        if (!found || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL prio_second: found=%b gnt=%b, required 0010", found, gnt);
        end
        req = '0;
        step();
        set_req(0, 2'b01, 8'h00);
        set_req(2, 2'b01, 8'h00);
        wait_gnt(found);
        checks++;
        if (!found || gnt !== 4'b0100) begin
            errors++;
            $display("FAIL prio_ptr: found=%b gnt=%b, required 0100", found, gnt);
        end
        req = '0;
        step();
    endtask

    task automatic test_stuck_bank();
        logic found;
        stuck = 1'b1;
        set_req(3, 2'b01, 8'h01);
        wait_gnt(found);
        checks++;
        if (!found || gnt !== 4'b1000 || err !== 1'b1) begin
            errors++;
            $display("FAIL stuck_set: found=%b gnt=%b err=%b, required 1000 err=1", found, gnt, err);
        end
        req = '0;
        step();
        set_req(3, 2'b00, 8'h01);
        wait_gnt(found);
        checks++;
        if (!found || gnt !== 4'b1000 || err !== 1'b0) begin
            errors++;
            $display("FAIL stuck_clr: found=%b gnt=%b err=%b, required 1000 err=0", found, gnt, err);
        end
        req = '0;
        stuck = 1'b0;
        step();
    endtask

    task automatic test_reset_abort();
        logic found;
        int spurious = 0;
        set_req(1, 2'b01, 8'h02);
        wait_gnt(found);
        req = '0;
        step();
        set_req(2, 2'b01, 8'h04);
        step();
        checks++;
        if (busy !== 1'b1 || j_out !== 8'h04) begin
            errors++;
            $display("FAIL abort_drive: busy=%b j=%h, required 1 04", busy, j_out);
        end
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || j_out !== '0 || k_out !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b j=%h k=%h gnt=%b, required all zero", busy, j_out, k_out, gnt);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (gnt != 0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL abort_gnt: %0d spurious grants, required 0", spurious);
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b01, 8'h10);
        wait_gnt(found);
        checks++;
        if (!found || gnt !== 4'b0001 || err !== 1'b0 || bank_q !== 8'h10) begin
            errors++;
            $display("FAIL abort_after: found=%b gnt=%b err=%b q=%h, required 0001 0 10", found, gnt, err, bank_q);
        end
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_set();
        test_toggle_load();
        test_zero_mask();
        test_back_to_back();
        test_priority();
        test_stuck_bank();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
